// File: rtl/param_bus_datapath.sv
// Single-bus register-transfer datapath with an internal micro-sequencer.
// One command per handshake is stepped through bus cycles T1..T4, then retired with a done pulse.
module param_bus_datapath #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [AW-1:0]    cmd_rc,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] bus_out,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned ZW = 2 * WIDTH;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [AW-1:0]     ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]  imm_q;
  logic              bad_q;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  y_q, hi_q, lo_q;
  logic [ZW-1:0]     z_q;
  logic [WIDTH-1:0]  bus_c;
  logic              cmd_bad_c;
  logic              accept_c;
  logic              short_c;

  function automatic logic idx_bad(input logic [AW-1:0] idx);
    return 32'(idx) >= NREGS;
  endfunction

  // Z result: low half only for ADD/SUB/AND/OR, full product for MUL
  function automatic logic [ZW-1:0] alu_f(input logic [2:0] op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] low;
    low = '0;
    case (op)
      OP_ADD:  low = a + b;
      OP_SUB:  low = a - b;
      OP_AND:  low = a & b;
      OP_OR:   low = a | b;
      default: low = '0;
    endcase
    if (op == OP_MUL) return ZW'(a) * ZW'(b);
    return {{WIDTH{1'b0}}, low};
  endfunction

  assign cmd_ready = (state_q == S_IDLE);
  assign accept_c  = cmd_valid && (state_q == S_IDLE);
  assign short_c   = (op_q == OP_MOV) || (op_q == OP_LDI);
  assign bus_out   = bus_c;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

  // Reject reserved op or any register index the op actually uses that is out of range
  always_comb begin
    cmd_bad_c = 1'b0;
    case (cmd_op)
      OP_MOV:  cmd_bad_c = idx_bad(cmd_ra) || idx_bad(cmd_rb);
      OP_LDI:  cmd_bad_c = idx_bad(cmd_ra);
      OP_MUL:  cmd_bad_c = idx_bad(cmd_rb) || idx_bad(cmd_rc);
      OP_RSV:  cmd_bad_c = 1'b1;
      default: cmd_bad_c = idx_bad(cmd_ra) || idx_bad(cmd_rb) || idx_bad(cmd_rc);
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (!idx_bad(rd_addr)) rd_data = regs_q[rd_addr];
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sequencer: each state selects exactly one bus source
  always_comb begin
    state_d = state_q;
    bus_c   = '0;
    case (state_q)
      S_IDLE: if (accept_c) state_d = cmd_bad_c ? S_DONE : S_T1;
      S_T1: begin
        bus_c   = (op_q == OP_LDI) ? imm_q : regs_q[rb_q];
        state_d = short_c ? S_DONE : S_T2;
      end
      S_T2: begin
        bus_c   = regs_q[rc_q];
        state_d = S_T3;
      end
      S_T3: begin
        bus_c   = z_q[WIDTH-1:0];
        state_d = (op_q == OP_MUL) ? S_T4 : S_DONE;
      end
      S_T4: begin
        bus_c   = z_q[ZW-1:WIDTH];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch and retire pulses
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      imm_q <= '0;
      bad_q <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept_c) begin
        op_q  <= cmd_op;
        ra_q  <= cmd_ra;
        rb_q  <= cmd_rb;
        rc_q  <= cmd_rc;
        imm_q <= cmd_imm;
        bad_q <= cmd_bad_c;
      end
      done <= (state_q == S_DONE);
      err  <= (state_q == S_DONE) && bad_q;
    end
  end

  // Bus destinations
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      y_q  <= '0;
      z_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      case (state_q)
        S_T1: begin
          if (short_c) regs_q[ra_q] <= bus_c;
          else         y_q          <= bus_c;
        end
        S_T2: z_q <= alu_f(op_q, y_q, bus_c);
        S_T3: begin
          if (op_q == OP_MUL) lo_q         <= bus_c;
          else                regs_q[ra_q] <= bus_c;
        end
        S_T4:    hi_q <= bus_c;
        default: ;
      endcase
    end
  end

endmodule
